// File: rtl/ospi_flash_ctrl.sv
// Host-side command sequencer for the OSPI flash model: chip-select framing, single enable strobe, response handshake.
// Optional write/erase read-back verify is enabled by defining OSPI_CTRL_VERIFY_EN.
module ospi_flash_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              flash_cs_n,
  output logic              flash_we,
  output logic              flash_re,
  output logic              flash_ee,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_wdata,
  input  logic [DATA_W-1:0] flash_rdata,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;
  localparam logic [2:0] S_VSTROBE = 3'd6;
  localparam logic [2:0] S_VCAPT   = 3'd7;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

`ifdef OSPI_CTRL_VERIFY_EN
  localparam logic VERIFY_EN = 1'b1;
`else
  localparam logic VERIFY_EN = 1'b0;
`endif

  localparam int CNT_MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX    = (CNT_MAX_SH > CS_IDLE) ? CNT_MAX_SH : CS_IDLE;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(CS_HOLD);
  localparam logic [CNT_W-1:0] L_IDLE  = CNT_W'(CS_IDLE);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic              r_cs_n;
  logic              r_we;
  logic              r_re;
  logic              r_ee;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] w_expect;

  // Read-back reference: erased cells read as all-ones
  always_comb begin
    w_expect = r_wdata;
    if (r_op == OP_ERASE) w_expect = '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_READ;
      r_cs_n      <= 1'b1;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_ee        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_rdata <= '0;
            if (cmd_op == OP_RSVD) begin
              r_err       <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_err   <= 1'b0;
              r_cs_n  <= 1'b0;
              r_cnt   <= L_SETUP;
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == L_ONE) begin
            r_re    <= (r_op == OP_READ);
            r_we    <= (r_op == OP_WRITE);
            r_ee    <= (r_op == OP_ERASE);
            r_state <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_STROBE: begin
          r_re    <= 1'b0;
          r_we    <= 1'b0;
          r_ee    <= 1'b0;
          r_cnt   <= L_HOLD;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          // Flash registers data_out on the edge ending STROBE, so it is valid during the first HOLD cycle
          if (r_op == OP_READ && r_cnt == L_HOLD) r_rdata <= flash_rdata;
          if (r_cnt == L_ONE) begin
            if (VERIFY_EN && r_op != OP_READ) begin
              r_re    <= 1'b1;
              r_state <= S_VSTROBE;
            end else begin
              r_cs_n      <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_VSTROBE: begin
          r_re    <= 1'b0;
          r_state <= S_VCAPT;
        end
        S_VCAPT: begin
          r_rdata     <= flash_rdata;
          r_err       <= (flash_rdata != w_expect);
          r_cs_n      <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= L_IDLE;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == L_ONE) r_state <= S_IDLE;
          else                r_cnt   <= r_cnt - L_ONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign flash_cs_n  = r_cs_n;
  assign flash_we    = r_we;
  assign flash_re    = r_re;
  assign flash_ee    = r_ee;
  assign flash_addr  = r_addr;
  assign flash_wdata = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Directed bench for ospi_flash_ctrl with a behavioural byte-wide flash model (optional bit-0 stuck-at-0).
module tb_ospi_flash_ctrl;

`ifdef OSPI_CTRL_VERIFY_EN
  localparam bit VFY = 1'b1;
  localparam int VX  = 2;
`else
  localparam bit VFY = 1'b0;
  localparam int VX  = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       flash_cs_n;
  logic       flash_we;
  logic       flash_re;
  logic       flash_ee;
  logic [7:0] flash_addr;
  logic [7:0] flash_wdata;
  logic [7:0] flash_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic       stuck0 = 1'b0;

  int t_cs_first, t_cs_last, t_cs_cnt, t_we, t_re, t_ee, t_strobe, t_overlap, t_en_hi, t_vcyc, t_rdy;
  logic [7:0] t_rd;
  logic       t_er;

  always #5 clk = ~clk;

  ospi_flash_ctrl #(
    .ADDR_W(8), .DATA_W(8), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .flash_cs_n(flash_cs_n), .flash_we(flash_we), .flash_re(flash_re), .flash_ee(flash_ee),
    .flash_addr(flash_addr), .flash_wdata(flash_wdata), .flash_rdata(flash_rdata),
    .busy(busy)
  );

  // Flash model: commands sampled while selected, data_out registered on the read strobe
  always @(posedge clk) begin
    if (flash_cs_n == 1'b0) begin
      if (flash_we) mem[flash_addr] <= flash_wdata;
      if (flash_ee) mem[flash_addr] <= 8'hFF;
      if (flash_re) flash_rdata <= stuck0 ? (mem[flash_addr] & 8'hFE) : mem[flash_addr];
    end
  end

  task automatic exec(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd);
    int waits;
    t_cs_first = -1; t_cs_last = -1; t_cs_cnt = 0; t_we = 0; t_re = 0; t_ee = 0;
    t_strobe = -1; t_overlap = 0; t_en_hi = 0; t_vcyc = -1; t_rdy = -1; t_rd = 8'h00; t_er = 1'b0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL exec_accept: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (flash_cs_n === 1'b0) begin
        if (t_cs_first < 0) t_cs_first = c;
        t_cs_last = c;
        t_cs_cnt++;
      end
      if (flash_we === 1'b1) t_we++;
      if (flash_re === 1'b1) t_re++;
      if (flash_ee === 1'b1) t_ee++;
      if (int'(flash_we) + int'(flash_re) + int'(flash_ee) > 1) t_overlap++;
      if ((flash_we | flash_re | flash_ee) === 1'b1) begin
        if (t_strobe < 0) t_strobe = c;
        if (flash_cs_n !== 1'b0) t_en_hi++;
      end
      if (rsp_valid === 1'b1 && t_vcyc < 0) begin
        t_vcyc = c; t_rd = rsp_rdata; t_er = rsp_err;
      end
      if (cmd_ready === 1'b1) begin
        t_rdy = c;
        break;
      end
    end
    if (t_rdy < 0) begin
      checks++; errors++;
      $display("FAIL exec_done: cmd_ready not back within 40 cycles");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({flash_cs_n, flash_we, flash_re, flash_ee, rsp_valid, rsp_err, cmd_ready, busy} !== 8'b1000_0010) begin
      errors++;
      $display("FAIL reset_ctrl: cs_n/we/re/ee/rv/err/rdy/busy=%b, required 10000010",
               {flash_cs_n, flash_we, flash_re, flash_ee, rsp_valid, rsp_err, cmd_ready, busy});
    end
    checks++;
    if ({flash_addr, flash_wdata, rsp_rdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: addr/wdata/rdata=%h, required 000000", {flash_addr, flash_wdata, rsp_rdata});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read();
    exec(2'b01, 8'h10, 8'hA5);
    checks++;
    if (t_we != 1 || t_ee != 0 || t_re != VX / 2 || t_en_hi != 0 || t_overlap != 0) begin
      errors++;
      $display("FAIL wr_strobe: we=%0d re=%0d ee=%0d en_cs_hi=%0d ovl=%0d, required 1 %0d 0 0 0",
               t_we, t_re, t_ee, t_en_hi, t_overlap, VX / 2);
    end
    checks++;
    if (t_cs_first != 1 || t_cs_last != 3 + VX || t_cs_cnt != 3 + VX || t_strobe != 2) begin
      errors++;
      $display("FAIL wr_cs: first=%0d last=%0d cnt=%0d strobe=%0d, required 1 %0d %0d 2",
               t_cs_first, t_cs_last, t_cs_cnt, t_strobe, 3 + VX, 3 + VX);
    end
    checks++;
    if (t_vcyc != 4 + VX || t_rd !== (VFY ? 8'hA5 : 8'h00) || t_er !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: vcyc=%0d rdata=%h err=%b, required %0d %h 0",
               t_vcyc, t_rd, t_er, 4 + VX, VFY ? 8'hA5 : 8'h00);
    end
    exec(2'b00, 8'h10, 8'h00);
    checks++;
    if (t_re != 1 || t_we != 0 || t_ee != 0 || t_strobe != 2 || t_cs_first != 1 || t_cs_last != 3) begin
      errors++;
      $display("FAIL rd_strobe: re=%0d we=%0d ee=%0d strobe=%0d cs=%0d..%0d, required 1 0 0 2 1..3",
               t_re, t_we, t_ee, t_strobe, t_cs_first, t_cs_last);
    end
    checks++;
    if (t_vcyc != 4 || t_rd !== 8'hA5 || t_er !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: vcyc=%0d rdata=%h err=%b, required 4 a5 0", t_vcyc, t_rd, t_er);
    end
    checks++;
    if (t_rdy != 7) begin
      errors++;
      $display("FAIL rd_ready: cmd_ready back at cycle %0d, required 7", t_rdy);
    end
    checks++;
    if (flash_addr !== 8'h10 || flash_wdata !== 8'h00) begin
      errors++;
      $display("FAIL addr_hold: addr=%h wdata=%h, required 10 00", flash_addr, flash_wdata);
    end
  endtask

  task automatic test_erase_sequence();
    exec(2'b01, 8'h20, 8'h3C);
    checks++;
    if (t_rdy - t_cs_last < 2) begin
      errors++;
      $display("FAIL gap_write: cs high %0d cycles, required >= 2", t_rdy - t_cs_last);
    end
    exec(2'b10, 8'h20, 8'h00);
    checks++;
    if (t_ee != 1 || t_we != 0 || t_re != VX / 2 || t_strobe != 2 || t_overlap != 0) begin
      errors++;
      $display("FAIL erase_strobe: ee=%0d we=%0d re=%0d strobe=%0d ovl=%0d, required 1 0 %0d 2 0",
               t_ee, t_we, t_re, t_strobe, t_overlap, VX / 2);
    end
    checks++;
    if (t_vcyc != 4 + VX || t_rd !== (VFY ? 8'hFF : 8'h00) || t_er !== 1'b0 || t_rdy - t_cs_last < 2) begin
      errors++;
      $display("FAIL erase_rsp: vcyc=%0d rdata=%h err=%b gap=%0d, required %0d %h 0 >=2",
               t_vcyc, t_rd, t_er, t_rdy - t_cs_last, 4 + VX, VFY ? 8'hFF : 8'h00);
    end
    exec(2'b00, 8'h20, 8'h00);
    checks++;
    if (t_rd !== 8'hFF || t_er !== 1'b0 || t_rdy - t_cs_last < 2) begin
      errors++;
      $display("FAIL erase_read: rdata=%h err=%b gap=%0d, required ff 0 >=2", t_rd, t_er, t_rdy - t_cs_last);
    end
  endtask

  task automatic test_reserved();
    exec(2'b11, 8'h05, 8'h99);
    checks++;
    if (t_cs_cnt != 0 || t_we + t_re + t_ee != 0) begin
      errors++;
      $display("FAIL rsvd_cs: cs low cycles=%0d strobes=%0d, required 0 0", t_cs_cnt, t_we + t_re + t_ee);
    end
    checks++;
    if (t_vcyc != 1 || t_er !== 1'b1 || t_rd !== 8'h00 || t_rdy != 4) begin
      errors++;
      $display("FAIL rsvd_rsp: vcyc=%0d err=%b rdata=%h rdy=%0d, required 1 1 00 4", t_vcyc, t_er, t_rd, t_rdy);
    end
  endtask

  task automatic test_backpressure();
    int stable, rdy_seen, we_seen, waits;
    stable = 0; rdy_seen = 0; we_seen = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = 8'h10; cmd_wdata = 8'h00; cmd_valid = 1'b1;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1 cmd_op = 2'b01; cmd_wdata = 8'h77;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) rdy_seen++;
      if (flash_we === 1'b1) we_seen++;
      if (c >= 4 && rsp_valid === 1'b1 && rsp_rdata === 8'hA5 && rsp_err === 1'b0) stable++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (stable != 10) begin
      errors++;
      $display("FAIL bp_stable: rsp held valid with a5 for %0d cycles, required 10", stable);
    end
    checks++;
    if (rdy_seen != 0 || we_seen != 0) begin
      errors++;
      $display("FAIL bp_ignore: cmd_ready cycles=%0d we cycles=%0d, required 0 0", rdy_seen, we_seen);
    end
    exec(2'b00, 8'h10, 8'h00);
    checks++;
    if (t_rd !== 8'hA5) begin
      errors++;
      $display("FAIL bp_noqueue: rdata=%h, required a5", t_rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int waits, bad;
    @(negedge clk);
    cmd_op = 2'b01; cmd_addr = 8'h30; cmd_wdata = 8'h55; cmd_valid = 1'b1;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (flash_we !== 1'b1 || flash_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_strobe: we=%b cs_n=%b, required 1 0", flash_we, flash_cs_n);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({flash_cs_n, flash_we, flash_re, flash_ee, rsp_valid, busy, cmd_ready} !== 7'b1000_001) begin
      errors++;
      $display("FAIL mid_reset: cs_n/we/re/ee/rv/busy/rdy=%b, required 1000001",
               {flash_cs_n, flash_we, flash_re, flash_ee, rsp_valid, busy, cmd_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || flash_cs_n !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_after: %0d cycles with response/busy/cs activity, required 0", bad);
    end
  endtask

  task automatic test_verify();
    stuck0 = 1'b1;
    exec(2'b01, 8'h40, 8'h01);
    checks++;
    if (t_er !== 1'b1 || t_rd !== 8'h00 || t_vcyc != 6) begin
      errors++;
      $display("FAIL vfy_bad: err=%b rdata=%h vcyc=%0d, required 1 00 6", t_er, t_rd, t_vcyc);
    end
    exec(2'b01, 8'h41, 8'h02);
    checks++;
    if (t_er !== 1'b0 || t_rd !== 8'h02) begin
      errors++;
      $display("FAIL vfy_good: err=%b rdata=%h, required 0 02", t_er, t_rd);
    end
    exec(2'b10, 8'h42, 8'h00);
    checks++;
    if (t_er !== 1'b1 || t_rd !== 8'hFE) begin
      errors++;
      $display("FAIL vfy_erase: err=%b rdata=%h, required 1 fe", t_er, t_rd);
    end
    stuck0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_erase_sequence();
    test_reserved();
    test_backpressure();
    test_reset_mid_op();
    if (VFY) test_verify();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
